// File: rtl/gshare_predictor_if.sv
`default_nettype none
// ============================================================================
// gshare_predictor_if : fetch-side prediction and commit-side update bundle.
// Revision: 1.0
// ============================================================================
interface gshare_predictor_if #(
  parameter int PC_W   = 32,
  parameter int CNT_W  = 2,
  parameter int HIST_W = 5
);
  logic              ready_o;
  logic              pred_valid_i;
  logic [PC_W-1:0]   pred_pc_i;
  logic              pred_taken_o;
  logic [CNT_W-1:0]  pred_counter_o;
  logic [HIST_W-1:0] pred_ghr_o;
  logic              upd_valid_i;
  logic [PC_W-1:0]   upd_pc_i;
  logic [HIST_W-1:0] upd_ghr_i;
  logic              upd_taken_i;
  logic              upd_mispredict_i;

  modport master (
    input  ready_o, pred_taken_o, pred_counter_o, pred_ghr_o,
    output pred_valid_i, pred_pc_i, upd_valid_i, upd_pc_i, upd_ghr_i,
           upd_taken_i, upd_mispredict_i
  );

  modport slave (
    output ready_o, pred_taken_o, pred_counter_o, pred_ghr_o,
    input  pred_valid_i, pred_pc_i, upd_valid_i, upd_pc_i, upd_ghr_i,
           upd_taken_i, upd_mispredict_i
  );
endinterface
`default_nettype wire

// File: rtl/gshare_predictor.sv
`default_nettype none
// ============================================================================
// gshare_predictor : PHT of saturating counters, speculative GHR, init sweep.
// GSHARE_EN defined -> index = PC ^ GHR; undefined -> PC-only (bimodal).
// Revision: 1.0
// ============================================================================
module gshare_predictor #(
  parameter int PC_W    = 32,
  parameter int PC_LSB  = 2,
  parameter int INDEX_W = 5,
  parameter int CNT_W   = 2,
  parameter int HIST_W  = 5
) (
  input  logic              clk,
  input  logic              rst,
  gshare_predictor_if.slave bus
);

  localparam int               DEPTH = 2**INDEX_W;
  localparam logic [CNT_W-1:0] CINIT = {1'b0, {(CNT_W-1){1'b1}}};
  localparam logic [CNT_W-1:0] CMAX  = {CNT_W{1'b1}};
`ifdef GSHARE_EN
  localparam bit HASH_EN = 1'b1;
`else
  localparam bit HASH_EN = 1'b0;
`endif

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [INDEX_W-1:0] init_ptr_q, init_ptr_d;
  logic [HIST_W-1:0]  ghr_q, ghr_d;
  logic [CNT_W-1:0]   pht_q [DEPTH];

  logic               pht_we;
  logic [INDEX_W-1:0] pht_waddr;
  logic [CNT_W-1:0]   pht_wdata;
  logic [INDEX_W-1:0] pred_idx, upd_idx;
  logic [CNT_W-1:0]   pred_cnt, upd_cnt;
  logic [HIST_W:0]    repair_hist, spec_hist;
  logic               run;

  function automatic logic [INDEX_W-1:0] pht_index(
    input logic [INDEX_W-1:0] pc_bits,
    input logic [HIST_W-1:0]  hist
  );
    logic [INDEX_W-1:0] hist_ext;
    hist_ext               = '0;
    hist_ext[HIST_W-1:0]   = hist;
    pht_index = pc_bits ^ (HASH_EN ? hist_ext : {INDEX_W{1'b0}});
  endfunction

  assign run      = (state_q == ST_RUN);
  assign pred_idx = pht_index(bus.pred_pc_i[PC_LSB +: INDEX_W], ghr_q);
  assign upd_idx  = pht_index(bus.upd_pc_i[PC_LSB +: INDEX_W], bus.upd_ghr_i);
  assign pred_cnt = pht_q[pred_idx];
  assign upd_cnt  = pht_q[upd_idx];

  // Shift-in by concatenation then truncation also covers HIST_W == 1.
  assign repair_hist = {bus.upd_ghr_i, bus.upd_taken_i};
  assign spec_hist   = {ghr_q, pred_cnt[CNT_W-1]};

  assign bus.ready_o        = run;
  assign bus.pred_counter_o = run ? pred_cnt : '0;
  assign bus.pred_taken_o   = run & pred_cnt[CNT_W-1];
  assign bus.pred_ghr_o     = run ? ghr_q : '0;

  always_comb begin
    state_d    = state_q;
    init_ptr_d = init_ptr_q;
    ghr_d      = ghr_q;
    pht_we     = 1'b0;
    pht_waddr  = init_ptr_q;
    pht_wdata  = CINIT;
    case (state_q)
      ST_INIT: begin
        pht_we     = 1'b1;
        init_ptr_d = init_ptr_q + 1'b1;
        if (&init_ptr_q) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (bus.upd_valid_i) begin
          pht_we    = 1'b1;
          pht_waddr = upd_idx;
          if (bus.upd_taken_i) begin
            pht_wdata = (upd_cnt == CMAX) ? upd_cnt : upd_cnt + 1'b1;
          end else begin
            pht_wdata = (upd_cnt == '0) ? upd_cnt : upd_cnt - 1'b1;
          end
        end
        // A commit-time repair overrides the speculative shift of this cycle.
        if (bus.upd_valid_i && bus.upd_mispredict_i) begin
          ghr_d = repair_hist[HIST_W-1:0];
        end else if (bus.pred_valid_i) begin
          ghr_d = spec_hist[HIST_W-1:0];
        end
      end
      default: begin
        state_d = ST_INIT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_INIT;
      init_ptr_q <= '0;
      ghr_q      <= '0;
    end else begin
      state_q    <= state_d;
      init_ptr_q <= init_ptr_d;
      ghr_q      <= ghr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && pht_we) begin
      pht_q[pht_waddr] <= pht_wdata;
    end
  end

  logic unused_bits;
  assign unused_bits = ^{bus.pred_pc_i, bus.upd_pc_i, repair_hist[HIST_W], spec_hist[HIST_W]};

endmodule
`default_nettype wire

// File: tb/tb_gshare_predictor.sv
`default_nettype none
// ============================================================================
// tb_gshare_predictor : scoreboard bench for gshare_predictor (either GSHARE_EN build).
// Revision: 1.0
// ============================================================================
module tb_gshare_predictor;
  localparam int PC_W = 32, PC_LSB = 2, INDEX_W = 5, CNT_W = 2, HIST_W = 5;
  localparam int DEPTH = 32;
`ifdef GSHARE_EN
  localparam bit GSHARE = 1'b1;
`else
  localparam bit GSHARE = 1'b0;
`endif

  typedef struct packed {
    logic              ready;
    logic              taken;
    logic [CNT_W-1:0]  cnt;
    logic [HIST_W-1:0] ghr;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];
  logic [CNT_W-1:0]  m_pht [DEPTH];
  logic [HIST_W-1:0] m_ghr;

  gshare_predictor_if #(.PC_W(PC_W), .CNT_W(CNT_W), .HIST_W(HIST_W)) bus ();

  gshare_predictor #(
    .PC_W(PC_W), .PC_LSB(PC_LSB), .INDEX_W(INDEX_W), .CNT_W(CNT_W), .HIST_W(HIST_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  function automatic logic [INDEX_W-1:0] m_idx(input logic [PC_W-1:0] pc, input logic [HIST_W-1:0] h);
    logic [INDEX_W-1:0] r;
    r = pc[PC_LSB +: INDEX_W];
    if (GSHARE) r = r ^ INDEX_W'(h);
    return r;
  endfunction

  // Reference model of one RUN cycle: returns outputs seen this cycle, then advances state.
  function automatic exp_t model_cycle(input logic pv, input logic [PC_W-1:0] ppc, input logic uv,
                                       input logic [PC_W-1:0] upc, input logic [HIST_W-1:0] ug,
                                       input logic ut, input logic um);
    exp_t e;
    logic [INDEX_W-1:0] u;
    e.ready = 1'b1;
    e.cnt   = m_pht[m_idx(ppc, m_ghr)];
    e.taken = e.cnt[CNT_W-1];
    e.ghr   = m_ghr;
    if (uv) begin
      u = m_idx(upc, ug);
      if (ut && m_pht[u] != 2'b11) m_pht[u] = m_pht[u] + 2'b01;
      else if (!ut && m_pht[u] != 2'b00) m_pht[u] = m_pht[u] - 2'b01;
    end
    if (uv && um) m_ghr = {ug[HIST_W-2:0], ut};
    else if (pv)  m_ghr = {m_ghr[HIST_W-2:0], e.taken};
    return e;
  endfunction

  task automatic drive(input logic pv, input logic [PC_W-1:0] ppc, input logic uv,
                       input logic [PC_W-1:0] upc, input logic [HIST_W-1:0] ug,
                       input logic ut, input logic um);
    bus.pred_valid_i     = pv;
    bus.pred_pc_i        = ppc;
    bus.upd_valid_i      = uv;
    bus.upd_pc_i         = upc;
    bus.upd_ghr_i        = ug;
    bus.upd_taken_i      = ut;
    bus.upd_mispredict_i = um;
  endtask

  // Drive a RUN-state cycle and push the model's expected outputs for it.
  task automatic apply(input logic pv, input logic [PC_W-1:0] ppc, input logic uv,
                       input logic [PC_W-1:0] upc, input logic [HIST_W-1:0] ug,
                       input logic ut, input logic um);
    drive(pv, ppc, uv, upc, ug, ut, um);
    exp_q.push_back(model_cycle(pv, ppc, uv, upc, ug, ut, um));
  endtask

  function automatic exp_t observe();
    return {bus.ready_o, bus.pred_taken_o, bus.pred_counter_o, bus.pred_ghr_o};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) m_pht[i] = 2'b01;
    m_ghr = '0;
  endtask

  // T1: one reset cycle, 32 INIT cycles with inputs ignored, then all reads 01.
  task automatic test_reset();
    exp_t e, got;
    logic [PC_W-1:0] pcs [4];
    pcs = '{32'h0, 32'h10, 32'h7c, 32'h0};
    pcs[3] = $urandom;
    rst = 1'b1;
    drive(1'b1, 32'h10, 1'b1, 32'h10, 5'b11111, 1'b1, 1'b1);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      exp_q.push_back('0);
      @(negedge clk);
      e = exp_q.pop_front(); got = observe();
      if (got !== e) begin
        errors++;
        $display("FAIL reset_init cycle %0d: got rdy/tk/cnt/ghr=%b required %b", i, got, e);
      end
      checks++;
      if (i == DEPTH-1) drive(1'b0, '0, 1'b0, '0, '0, 1'b0, 1'b0);
      @(posedge clk); #1;
    end
    model_reset();
    for (int k = 0; k < 4; k++) begin
      apply(1'b0, pcs[k], 1'b0, '0, '0, 1'b0, 1'b0);
      @(negedge clk);
      e = exp_q.pop_front(); got = observe();
      if (got !== e || got.cnt !== 2'b01) begin
        errors++;
        $display("FAIL reset_read pc=%h: got rdy/tk/cnt/ghr=%b required %b", pcs[k], got, e);
      end
      checks++;
      @(posedge clk); #1;
    end
  endtask

  // T2: saturating up/down on pc 0x10 with back-to-back chained updates.
  task automatic test_saturate();
    exp_t e, got;
    logic [CNT_W-1:0] want [8];
    logic tk [8];
    want = '{2'b01, 2'b10, 2'b11, 2'b11, 2'b10, 2'b01, 2'b00, 2'b00};
    tk   = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 8; i++) begin
      apply(1'b0, 32'h10, (i < 7), 32'h10, '0, tk[i], 1'b0);
      @(negedge clk);
      e = exp_q.pop_front(); got = observe();
      if (got !== e || got.cnt !== want[i]) begin
        errors++;
        $display("FAIL saturate step %0d: got rdy/tk/cnt/ghr=%b required %b (cnt %b)", i, got, e, want[i]);
      end
      checks++;
      @(posedge clk); #1;
    end
  endtask

  // T3: two trainings, then speculative shifts with counters 10,10,01.
  task automatic test_ghr_shift();
    exp_t e, got;
    logic            pv [6];
    logic [PC_W-1:0] ppc [6];
    logic            uv [6];
    logic [PC_W-1:0] upc [6];
    logic [HIST_W-1:0] ug [6];
    logic [HIST_W-1:0] wghr [6];
    pv   = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    ppc  = '{32'h0, 32'h0, 32'h20, 32'h30, 32'h50, 32'h0};
    uv   = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    upc  = '{32'h20, 32'h30, 32'h0, 32'h0, 32'h0, 32'h0};
    ug   = '{5'b00000, 5'b00001, 5'b0, 5'b0, 5'b0, 5'b0};
    wghr = '{5'b00000, 5'b00000, 5'b00000, 5'b00001, 5'b00011, 5'b00110};
    for (int i = 0; i < 6; i++) begin
      apply(pv[i], ppc[i], uv[i], upc[i], ug[i], 1'b1, 1'b0);
      @(negedge clk);
      e = exp_q.pop_front(); got = observe();
      if (got !== e || got.ghr !== wghr[i]) begin
        errors++;
        $display("FAIL ghr_shift step %0d: got rdy/tk/cnt/ghr=%b required %b (ghr %b)", i, got, e, wghr[i]);
      end
      checks++;
      @(posedge clk); #1;
    end
  endtask

  // T4: repair beats a same-cycle speculative shift; then a lone taken repair.
  task automatic test_repair();
    exp_t e, got;
    logic            pv [4];
    logic            um [4];
    logic [HIST_W-1:0] ug [4];
    logic            ut [4];
    pv = '{1'b1, 1'b0, 1'b0, 1'b1};
    um = '{1'b1, 1'b0, 1'b1, 1'b0};
    ug = '{5'b10101, 5'b0, 5'b00110, 5'b0};
    ut = '{1'b0, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 4; i++) begin
      apply(pv[i], 32'h40, um[i], 32'h60, ug[i], ut[i], um[i]);
      @(negedge clk);
      e = exp_q.pop_front(); got = observe();
      if (got !== e) begin
        errors++;
        $display("FAIL repair step %0d: got rdy/tk/cnt/ghr=%b required %b", i, got, e);
      end
      checks++;
      if (i == 1 && got.ghr !== 5'b01010) begin
        errors++;
        $display("FAIL repair_value: got ghr %b required 01010", got.ghr);
      end
      if (i == 1) checks++;
      if (i == 3 && got.ghr !== 5'b01101) begin
        errors++;
        $display("FAIL repair_taken: got ghr %b required 01101", got.ghr);
      end
      if (i == 3) checks++;
      @(posedge clk); #1;
    end
  endtask

  // T5: GHR 00011 with pc 0x10 -> entry 7 under gshare, entry 4 under bimodal.
  task automatic test_index();
    exp_t e, got;
    logic            uv [6];
    logic [HIST_W-1:0] ug [6];
    logic            ut [6];
    logic            um [6];
    logic [PC_W-1:0] upc [6];
    logic [CNT_W-1:0] want [6];
    uv   = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    upc  = '{32'h7c, 32'h10, 32'h0, 32'h7c, 32'h0, 32'h0};
    ug   = '{5'b00001, 5'b00011, 5'b0, 5'b00000, 5'b0, 5'b0};
    ut   = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    um   = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    want = GSHARE ? '{2'bxx, 2'b01, 2'b10, 2'bxx, 2'b00, 2'b00}
                  : '{2'bxx, 2'b00, 2'b01, 2'bxx, 2'b01, 2'b01};
    for (int i = 0; i < 6; i++) begin
      apply(1'b0, 32'h10, uv[i], upc[i], ug[i], ut[i], um[i]);
      @(negedge clk);
      e = exp_q.pop_front(); got = observe();
      if (got !== e) begin
        errors++;
        $display("FAIL index step %0d: got rdy/tk/cnt/ghr=%b required %b", i, got, e);
      end
      checks++;
      if ((i == 1 || i == 2 || i == 4) && got.cnt !== want[i]) begin
        errors++;
        $display("FAIL index_entry step %0d: got cnt %b required %b", i, got.cnt, want[i]);
      end
      if (i == 1 || i == 2 || i == 4) checks++;
      @(posedge clk); #1;
    end
  endtask

  // T6: reset in RUN, again mid-sweep at init_ptr 12, then full sweep and clean table.
  task automatic test_reset_mid();
    exp_t e, got;
    apply(1'b0, '0, 1'b1, 32'h24, 5'b10101, 1'b1, 1'b1);
    @(posedge clk); #1;
    void'(exp_q.pop_front());
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    drive(1'b1, 32'h10, 1'b1, 32'h10, 5'b11111, 1'b1, 1'b1);
    repeat (12) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      exp_q.push_back('0);
      @(negedge clk);
      e = exp_q.pop_front(); got = observe();
      if (got !== e) begin
        errors++;
        $display("FAIL resweep cycle %0d: got rdy/tk/cnt/ghr=%b required %b", i, got, e);
      end
      checks++;
      if (i == DEPTH-1) drive(1'b0, '0, 1'b0, '0, '0, 1'b0, 1'b0);
      @(posedge clk); #1;
    end
    model_reset();
    for (int k = 0; k < DEPTH; k++) begin
      apply(1'b0, PC_W'(k) << PC_LSB, 1'b0, '0, '0, 1'b0, 1'b0);
      @(negedge clk);
      e = exp_q.pop_front(); got = observe();
      if (got !== e || got !== 9'b1_0_01_00000) begin
        errors++;
        $display("FAIL resweep_entry %0d: got rdy/tk/cnt/ghr=%b required %b", k, got, e);
      end
      checks++;
      @(posedge clk); #1;
    end
  endtask

  initial begin
    rst = 1'b0;
    drive(1'b0, '0, 1'b0, '0, '0, 1'b0, 1'b0);
    model_reset();
    @(posedge clk); #1;
    test_reset();
    test_saturate();
    test_ghr_shift();
    test_repair();
    test_index();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
